// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 control path: opcodes, ALU operand/op selects, sequencer states.
// Both the single-cycle decoder and the multi-cycle sequencer use these opcode constants.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_CTZ    = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_CTZ    = 2'b11;

  localparam logic [1:0] SRC_A_RS1 = 2'b00;
  localparam logic [1:0] SRC_A_PC  = 2'b01;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StBranch,
    StTrap
  } ctrl_state_e;

  typedef enum logic {
    CauseIllegal    = 1'b0,
    CauseMemTimeout = 1'b1
  } trap_cause_e;

  function automatic logic is_exec_opcode(logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_CTZ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake between the multi-cycle sequencer (master) and the datapath/memory side (slave).
interface multicycle_ctrl_fsm_if;

  logic       run;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic       trap;
  logic       trap_cause;

  modport master (
    input  run, opcode, branch_taken, mem_ready,
    output mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, mem_to_reg, reg_write, instr_done, trap, trap_cause
  );

  modport slave (
    output run, opcode, branch_taken, mem_ready,
    input  mem_req, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, mem_to_reg, reg_write, instr_done, trap, trap_cause
  );

endinterface

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive cycles a memory request waits on mem_ready; flags expiry at MaxWait.
module mem_wait_watchdog #(
  parameter int unsigned MaxWait = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic expired_o
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] Limit = CntW'(MaxWait);

  logic [CntW-1:0] count_q, count_d;

  // Outside a waiting state the count is held at zero, so entry into FETCH/MEM starts fresh.
  always_comb begin
    count_d = count_q;
    if (!active_i || mem_ready_i) begin
      count_d = '0;
    end else if (count_q != Limit) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = active_i && !mem_ready_i && (count_q == Limit);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/BRANCH with sticky TRAP.
// Optional PERF_COUNTERS_EN adds cycle_count_o / instret_count_o.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PERF_COUNTERS_EN
  output logic [31:0] cycle_count_o,
  output logic [31:0] instret_count_o,
`endif
  multicycle_ctrl_fsm_if.master bus
);

  ctrl_state_e state_q, state_d;
  trap_cause_e trap_cause_q, trap_cause_d;

  logic       wd_expired;
  logic       mem_req, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       mem_to_reg, reg_write, instr_done;
  logic       is_load, is_store;
  logic       retire_next;

  assign is_load  = (bus.opcode == OP_LOAD);
  assign is_store = (bus.opcode == OP_STORE);

  mem_wait_watchdog #(
    .MaxWait(MAX_WAIT)
  ) u_watchdog (
    .clk_i      (clk),
    .rst_i      (rst),
    .active_i   ((state_q == StFetch) || (state_q == StMem)),
    .mem_ready_i(bus.mem_ready),
    .expired_o  (wd_expired)
  );

  // run is only consulted at instruction boundaries.
  assign retire_next = bus.run;

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    mem_req      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_OP_ADD;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    instr_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (wd_expired) begin
          state_d      = StTrap;
          trap_cause_d = CauseMemTimeout;
        end
      end
      StDecode: begin
        // Branch target is computed here and parked in ALUOut.
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_IMM;
        if (bus.opcode == OP_BRANCH) begin
          state_d = StBranch;
        end else if (is_exec_opcode(bus.opcode)) begin
          state_d = StExecute;
        end else begin
          state_d      = StTrap;
          trap_cause_d = CauseIllegal;
        end
      end
      StExecute: begin
        case (bus.opcode)
          OP_R: begin
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_FUNCT;
          end
          OP_I: begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ADD;
          end
          OP_CTZ: begin
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_CTZ;
          end
          default: ;
        endcase
        state_d = (is_load || is_store) ? StMem : StWriteback;
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        if (bus.mem_ready) begin
          if (is_load) begin
            state_d = StWriteback;
          end else begin
            instr_done = 1'b1;
            state_d    = retire_next ? StFetch : StIdle;
          end
        end else if (wd_expired) begin
          state_d      = StTrap;
          trap_cause_d = CauseMemTimeout;
        end
      end
      StWriteback: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        instr_done = 1'b1;
        state_d    = retire_next ? StFetch : StIdle;
      end
      StBranch: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_BRANCH;
        pc_src     = 1'b1;
        pc_write   = bus.branch_taken;
        instr_done = 1'b1;
        state_d    = retire_next ? StFetch : StIdle;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      trap_cause_q <= CauseIllegal;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.instr_done = instr_done;
  assign bus.trap       = (state_q == StTrap);
  assign bus.trap_cause = (state_q == StTrap) && (trap_cause_q == CauseMemTimeout);

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instret_count_q, instret_count_d;

  // Both freeze in TRAP: no active cycles and no retirements occur there.
  always_comb begin
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;
    if ((state_q != StIdle) && (state_q != StTrap)) cycle_count_d = cycle_count_q + 32'd1;
    if (instr_done) instret_count_d = instret_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q   <= '0;
      instret_count_q <= '0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cycle_count_o   = cycle_count_q;
  assign instret_count_o = instret_count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus queues expected per-instruction summaries,
// a negedge monitor accumulates what the DUT drove and compares on retire or trap.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned MaxWait = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus_if ();

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  multicycle_ctrl_fsm #(
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef PERF_COUNTERS_EN
    .cycle_count_o  (cycle_count),
    .instret_count_o(instret_count),
`endif
    .bus            (bus_if)
  );

  typedef struct {
    string      name;
    bit         is_trap;
    bit         cause;
    int         cycles;
    int         reqs;
    int         rws;
    bit         m2r;
    bit         pcw;
    bit         pcs;
    logic [1:0] op;
    logic [1:0] srcb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  // Memory responder knobs.
  int   fetch_wait = 0;
  int   mem_wait   = 0;
  bit   stuck      = 1'b0;
  int   wait_cnt   = 0;
  bit   prev_req   = 1'b0;
  bit   prev_rdy   = 1'b0;

  // Monitor accumulators.
  bit         in_instr   = 1'b0;
  bit         trap_seen  = 1'b0;
  bit         ex_seen    = 1'b0;
  int         m_cyc, m_req, m_rw;
  bit         m_m2r, m_pcw, m_pcs;
  logic [1:0] m_op, m_b;

  task automatic check(string nm, int act, int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(bit tr, bit cause, int cyc, int reqs, int rws, bit m2r, bit pcw,
                              bit pcs, logic [1:0] op, logic [1:0] srcb);
    exp_t e;
    e.name = ""; e.is_trap = tr; e.cause = cause; e.cycles = cyc; e.reqs = reqs; e.rws = rws;
    e.m2r = m2r; e.pcw = pcw; e.pcs = pcs; e.op = op; e.srcb = srcb;
    return e;
  endfunction

  function automatic int outs();
    return int'({bus_if.mem_req, bus_if.mem_read, bus_if.mem_write, bus_if.ir_write,
                 bus_if.pc_write, bus_if.pc_src, bus_if.alu_src_a, bus_if.alu_src_b,
                 bus_if.alu_op, bus_if.mem_to_reg, bus_if.reg_write, bus_if.instr_done});
  endfunction

  task automatic finalize(bit tr, bit cause);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({e.name, "_is_trap"}, int'(tr), int'(e.is_trap));
      check({e.name, "_cycles"}, m_cyc, e.cycles);
      if (e.is_trap) begin
        check({e.name, "_trap_cause"}, int'(cause), int'(e.cause));
      end else begin
        check({e.name, "_mem_req_cycles"}, m_req, e.reqs);
        check({e.name, "_reg_write_cycles"}, m_rw, e.rws);
        check({e.name, "_mem_to_reg"}, int'(m_m2r), int'(e.m2r));
        check({e.name, "_pc_write"}, int'(m_pcw), int'(e.pcw));
        check({e.name, "_pc_src"}, int'(m_pcs), int'(e.pcs));
        check({e.name, "_alu_op"}, int'(m_op), int'(e.op));
        check({e.name, "_alu_src_b"}, int'(m_b), int'(e.srcb));
      end
    end
    done_cnt++;
  endtask

  // Responder: mem_ready rises once the current request has waited the programmed cycles.
  initial begin
    bus_if.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) wait_cnt = 0;
      else if (prev_req) wait_cnt = prev_rdy ? 0 : wait_cnt + 1;
      if (bus_if.mem_req && !stuck && !rst)
        bus_if.mem_ready = (wait_cnt >= ((bus_if.alu_src_a == 2'b01) ? fetch_wait : mem_wait));
      else
        bus_if.mem_ready = 1'b0;
    end
  end

  // Monitor.
  initial begin
    forever begin
      @(negedge clk);
      prev_req = bus_if.mem_req;
      prev_rdy = bus_if.mem_ready;
      if (rst) begin
        in_instr  = 1'b0;
        trap_seen = 1'b0;
      end else begin
        if (!in_instr && !bus_if.trap && bus_if.mem_req && bus_if.mem_read &&
            bus_if.alu_src_a == 2'b01) begin
          in_instr = 1'b1; ex_seen = 1'b0;
          m_cyc = 0; m_req = 0; m_rw = 0; m_op = 2'b00; m_b = 2'b00;
        end
        if (in_instr) begin
          if (bus_if.trap) begin
            if (!trap_seen) finalize(1'b1, bus_if.trap_cause);
            trap_seen = 1'b1;
            in_instr  = 1'b0;
          end else begin
            m_cyc++;
            if (bus_if.mem_req) m_req++;
            if (bus_if.reg_write) m_rw++;
            if (!ex_seen && bus_if.alu_src_a == 2'b00) begin
              ex_seen = 1'b1; m_op = bus_if.alu_op; m_b = bus_if.alu_src_b;
            end
            if (bus_if.instr_done) begin
              m_m2r = bus_if.mem_to_reg; m_pcw = bus_if.pc_write; m_pcs = bus_if.pc_src;
              finalize(1'b0, 1'b0);
              in_instr = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic do_instr(string nm, logic [6:0] op, bit taken, int fw, int mw, exp_t e);
    int start;
    bit got;
    bus_if.opcode = op; bus_if.branch_taken = taken;
    fetch_wait = fw; mem_wait = mw;
    e.name = nm;
    exp_q.push_back(e);
    start = done_cnt;
    @(posedge clk); #1 bus_if.run = 1'b1;
    @(posedge clk); #1 bus_if.run = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done_cnt != start) got = 1'b1;
    end
    if (!got) begin
      check({nm, "_timeout"}, 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit got;
    rst = 1'b1; bus_if.run = 1'b0; bus_if.opcode = 7'd0; bus_if.branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    check("reset_trap", int'(bus_if.trap), 0);
    check("reset_trap_cause", int'(bus_if.trap_cause), 0);
    @(posedge clk); #1 rst = 1'b0;

    do_instr("add", 7'b0110011, 1'b0, 0, 0, mk(0, 0, 4, 1, 1, 0, 0, 0, 2'b10, 2'b00));
    @(negedge clk);
    check("idle_after_retire", outs(), 0);
    do_instr("addi_fwait2", 7'b0010011, 1'b0, 2, 0, mk(0, 0, 6, 3, 1, 0, 0, 0, 2'b10, 2'b10));
    do_instr("lw_mwait3", 7'b0000011, 1'b0, 0, 3, mk(0, 0, 8, 5, 1, 1, 0, 0, 2'b00, 2'b10));
    do_instr("sw", 7'b0100011, 1'b0, 0, 0, mk(0, 0, 4, 2, 0, 0, 0, 0, 2'b00, 2'b10));
    do_instr("ctz", 7'b1110011, 1'b0, 0, 0, mk(0, 0, 4, 1, 1, 0, 0, 0, 2'b11, 2'b00));
    do_instr("beq_taken", 7'b1100011, 1'b1, 0, 0, mk(0, 0, 3, 1, 0, 0, 1, 1, 2'b01, 2'b00));
    do_instr("beq_not", 7'b1100011, 1'b0, 0, 0, mk(0, 0, 3, 1, 0, 0, 0, 1, 2'b01, 2'b00));
    do_instr("add_fwait_max", 7'b0110011, 1'b0, 4, 0, mk(0, 0, 8, 5, 1, 0, 0, 0, 2'b10, 2'b00));
    do_instr("lw_mwait_max", 7'b0000011, 1'b0, 0, 4, mk(0, 0, 9, 6, 1, 1, 0, 0, 2'b00, 2'b10));

    // Illegal opcode: sticky trap ignoring run.
    do_instr("illegal", 7'b1111111, 1'b0, 0, 0, mk(1, 0, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    bus_if.run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("trap_outputs_zero", outs(), 0);
      check("trap_sticky", int'(bus_if.trap), 1);
    end
    bus_if.run = 1'b0;
    pulse_reset();
    @(negedge clk);
    check("rst_clears_trap", int'(bus_if.trap), 0);

    // Fetch stuck: watchdog trap with mem_req dropped.
    stuck = 1'b1;
    do_instr("fetch_timeout", 7'b0110011, 1'b0, 0, 0, mk(1, 1, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    @(negedge clk);
    check("timeout_mem_req_dropped", int'(bus_if.mem_req), 0);
    check("timeout_cause", int'(bus_if.trap_cause), 1);
    stuck = 1'b0;
    pulse_reset();

    // Reset in the middle of a store's MEM phase.
    bus_if.opcode = 7'b0100011; fetch_wait = 0; mem_wait = 20;
    @(posedge clk); #1 bus_if.run = 1'b1;
    @(posedge clk); #1 bus_if.run = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_if.mem_write) got = 1'b1;
    end
    check("sw_reached_mem", int'(got), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_req", int'(bus_if.mem_req), 0);
    check("async_rst_mem_write", int'(bus_if.mem_write), 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    mem_wait = 0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", outs(), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Sequencing controller for the multi-cycle RV32 core variant. It steps one instruction at a time through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared ALU and a single unified memory port. It drives the same control intent as the single-cycle decoder (branch, memRead, memtoReg, ALUOp, memWrite, ALUSrc, regWrite), with a memory req/ready handshake, a wait watchdog and a sticky trap state.

Parameters:
MAX_WAIT, 16, cycles mem_ready may stay low in FETCH/MEM before TRAP (1..255).

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
run  in  1  enable; sampled in IDLE and at instruction boundaries.
opcode  in  7  IR[6:0]; valid from DECODE onward.
branch_taken  in  1  comparator result for current B-type; valid in BRANCH.
mem_ready  in  1  memory completes current request this cycle.
mem_req  out  1  memory request, held until mem_ready.
mem_read  out  1  read qualifier (FETCH, LW MEM).
mem_write  out  1  write qualifier (SW MEM).
ir_write  out  1  load IR.
pc_write  out  1  load PC.
pc_src  out  1  0 = ALU result (PC+4); 1 = ALUOut (branch target).
alu_src_a  out  2  00 rs1, 01 PC.
alu_src_b  out  2  00 rs2, 01 const 4, 10 imm.
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 CTZ.
mem_to_reg  out  1  writeback selects memory data.
reg_write  out  1  register-file write enable.
instr_done  out  1  one-cycle pulse on an instruction's final cycle.
trap  out  1  sticky; set on illegal opcode or watchdog expiry.
trap_cause  out  1  0 illegal opcode, 1 memory timeout; valid while trap=1.

Behaviour:
- Reset (async): state=IDLE, wait counter=0, trap=0, trap_cause=0. Every output is 0 in IDLE.
- Outputs are decoded from registered state; ir_write, pc_write and instr_done also depend on mem_ready/branch_taken in the same cycle.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: mem_req=1, mem_read=1, alu_src_a=01, alu_src_b=01, alu_op=00, pc_src=0.
  - On mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (1 cycle): alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Opcode 1100011 -> BRANCH.
  - Opcodes 0110011, 0010011, 0000011, 0100011, 1110011 -> EXECUTE.
  - Any other opcode -> TRAP with cause 0.
- EXECUTE (1 cycle): alu_src_a=00.
  - R-type: b=00, op=10.
  - I-type: b=10, op=10.
  - LW/SW: b=10, op=00.
  - CTZ: b=00, op=11.
  - LW/SW -> MEM; all others -> WRITEBACK.
- MEM: mem_req=1; mem_read=1 for LW, mem_write=1 for SW.
  - Advance on mem_ready: LW -> WRITEBACK; SW retires (instr_done=1).
  - Otherwise increment the wait counter.
- WRITEBACK (1 cycle): reg_write=1, mem_to_reg=1 only for LW, instr_done=1.
- BRANCH (1 cycle): alu_src_a=00, alu_src_b=00, alu_op=01, pc_src=1, pc_write=branch_taken, instr_done=1.
- Retire: next state is FETCH if run=1, else IDLE. run is ignored mid-instruction.
- Latency with zero-wait memory: R/I/CTZ 4 cycles, LW 5, SW 4, B 3. Each mem_ready-low cycle adds 1.
- Watchdog:
  - The counter clears on entering FETCH or MEM, and on mem_ready=1.
  - When it reaches MAX_WAIT with mem_ready still low -> TRAP with cause 1. The request drops (mem_req=0).
  - mem_ready=1 on the same cycle the count hits MAX_WAIT counts as completion (no trap).
- TRAP: all control outputs 0, trap=1. Exits only via rst; run is ignored.
- Reset mid-operation, e.g. during MEM with mem_req high, drops all outputs immediately (asynchronously).

Optional Feature:
PERF_COUNTERS_EN
- Defined: adds outputs cycle_count[31:0] and instret_count[31:0].
  - cycle_count increments every cycle the state is not IDLE or TRAP.
  - instret_count increments on each instr_done.
  - Both wrap at 2^32, reset to 0, and freeze in TRAP.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package rv_ctrl_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_CTZ);
  - ALUOp encodings;
  - alu_src_a/b encodings;
  - state enum (IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, BRANCH, TRAP).
  - The single-cycle decoder uses the same opcode constants.
- One sub-module: mem_wait_watchdog (counter, clear/enable, expired flag); everything else is inline.

Test Plan:
- ADD, opcode 0110011, run=1, mem_ready tied 1 -> states FETCH, DECODE, EXECUTE, WRITEBACK; reg_write=1 only in cycle 4 with alu_op=10, alu_src_b=00; instr_done pulses in cycle 4.
- LW with mem_ready low 3 cycles in MEM -> mem_req/mem_read held 4 cycles; WRITEBACK has mem_to_reg=1; total 8 cycles.
- BEQ with branch_taken=1, then branch_taken=0 -> pc_write=1, pc_src=1 in cycle 3; second instruction has pc_write=0; both take 3 cycles.
- Opcode 1111111 -> TRAP after DECODE; trap=1, trap_cause=0; all outputs 0 for 20 cycles; rst clears trap.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH -> TRAP with cause 1 after 4 wait cycles; second run with mem_ready=1 exactly at count 4 -> no trap.
- rst asserted mid-MEM of an SW, and run=0 at a retire boundary -> outputs drop same cycle (async); after retire, state returns to IDLE with mem_req=0.
